// File: rtl/age_issue_queue.sv
// rtl/age_issue_queue.sv - age-matrix out-of-order issue queue
//
// Purpose: holds dispatched ALU ops until both source operands are available
// and then issues them to the ALU pipes, always oldest-first. Relative age is
// held in an age matrix (bit[i][j]=1 means entry i is older than entry j).
// Because of this there are no age tags that can wrap.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard every entry on the next edge
//   disp_*              dispatch lanes (valid per lane, one shared ready)
//   wb_*                writeback buses that wake waiting source operands
//   iss_*               issue ports (valid/ready per port)
//   free_count          number of invalid entries
module age_issue_queue #(
   parameter int DEPTH          = 8,
   parameter int DISPATCH_WIDTH = 2,
   parameter int ISSUE_WIDTH    = 2,
   parameter int WB_WIDTH       = 2,
   parameter int XLEN           = 32,
   parameter int PREG_W         = 6,
   parameter int ROB_W          = 4,
   parameter int CMD_W          = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic [DISPATCH_WIDTH-1:0]        disp_valid,
   output logic                             disp_ready,
   input  logic [DISPATCH_WIDTH*CMD_W-1:0]  disp_alu_cmd,
   input  logic [DISPATCH_WIDTH-1:0]        disp_src1_rdy,
   input  logic [DISPATCH_WIDTH-1:0]        disp_src2_rdy,
   input  logic [DISPATCH_WIDTH*XLEN-1:0]   disp_src1,
   input  logic [DISPATCH_WIDTH*XLEN-1:0]   disp_src2,
   input  logic [DISPATCH_WIDTH*PREG_W-1:0] disp_rd,
   input  logic [DISPATCH_WIDTH*ROB_W-1:0]  disp_rob,
   input  logic [WB_WIDTH-1:0]              wb_valid,
   input  logic [WB_WIDTH*PREG_W-1:0]       wb_preg,
   input  logic [WB_WIDTH*XLEN-1:0]         wb_data,
   output logic [ISSUE_WIDTH-1:0]           iss_valid,
   input  logic [ISSUE_WIDTH-1:0]           iss_ready,
   output logic [ISSUE_WIDTH*CMD_W-1:0]     iss_alu_cmd,
   output logic [ISSUE_WIDTH*XLEN-1:0]      iss_src1,
   output logic [ISSUE_WIDTH*XLEN-1:0]      iss_src2,
   output logic [ISSUE_WIDTH*PREG_W-1:0]    iss_rd,
   output logic [ISSUE_WIDTH*ROB_W-1:0]     iss_rob,
   output logic [$clog2(DEPTH+1)-1:0]       free_count
);

   localparam int IDXW = $clog2(DEPTH);
   localparam int FCW  = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  r_age [DEPTH];
   logic [CMD_W-1:0]  r_cmd [DEPTH];
   logic [DEPTH-1:0]  r_s1_rdy;
   logic [DEPTH-1:0]  r_s2_rdy;
   logic [XLEN-1:0]   r_s1_val [DEPTH];
   logic [XLEN-1:0]   r_s2_val [DEPTH];
   logic [PREG_W-1:0] r_rd [DEPTH];
   logic [ROB_W-1:0]  r_rob [DEPTH];

   logic [FCW-1:0]            w_free_cnt;
   logic [DEPTH-1:0]          w_s1_hit, w_s2_hit;
   logic [XLEN-1:0]           w_s1_wdat [DEPTH];
   logic [XLEN-1:0]           w_s2_wdat [DEPTH];
   logic [DISPATCH_WIDTH-1:0] w_d1_hit, w_d2_hit;
   logic [XLEN-1:0]           w_d1_wdat [DISPATCH_WIDTH];
   logic [XLEN-1:0]           w_d2_wdat [DISPATCH_WIDTH];
   logic [DISPATCH_WIDTH-1:0] w_alloc_en;
   logic [IDXW-1:0]           w_alloc_idx [DISPATCH_WIDTH];
   logic [DEPTH-1:0]          w_alloc_mask;
   logic [ISSUE_WIDTH-1:0]    w_sel_v;
   logic [IDXW-1:0]           w_sel_idx [ISSUE_WIDTH];
   logic [DEPTH-1:0]          w_issue_mask;
   logic [DEPTH-1:0]          w_age_n [DEPTH];

   // Returns {hit, data}; iterating downward lets the lowest matching port win.
   function automatic logic [XLEN:0] f_wake(input logic [PREG_W-1:0] tag,
                                            input logic [WB_WIDTH-1:0] v,
                                            input logic [WB_WIDTH*PREG_W-1:0] p,
                                            input logic [WB_WIDTH*XLEN-1:0] d);
      logic [XLEN:0] res;
      res = '0;
      for (int w = WB_WIDTH-1; w >= 0; w--) begin
         if (v[w] && (p[w*PREG_W +: PREG_W] == tag)) res = {1'b1, d[w*XLEN +: XLEN]};
      end
      return res;
   endfunction

   always_comb begin
      w_free_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!r_valid[i]) w_free_cnt = w_free_cnt + FCW'(1);
      end
   end

   assign free_count = w_free_cnt;
   assign disp_ready = (w_free_cnt >= FCW'(DISPATCH_WIDTH)) && !flush;

   // Wakeup matches for stored entries and for lanes being dispatched now.
   always_comb begin
      w_s1_hit = '0;
      w_s2_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         {w_s1_hit[i], w_s1_wdat[i]} = f_wake(r_s1_val[i][PREG_W-1:0], wb_valid, wb_preg, wb_data);
         {w_s2_hit[i], w_s2_wdat[i]} = f_wake(r_s2_val[i][PREG_W-1:0], wb_valid, wb_preg, wb_data);
      end
      w_d1_hit = '0;
      w_d2_hit = '0;
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
         {w_d1_hit[l], w_d1_wdat[l]} = f_wake(disp_src1[l*XLEN +: PREG_W], wb_valid, wb_preg, wb_data);
         {w_d2_hit[l], w_d2_wdat[l]} = f_wake(disp_src2[l*XLEN +: PREG_W], wb_valid, wb_preg, wb_data);
      end
   end

   // The k-th active lane takes the k-th lowest free slot. Slots freed by
   // issue this cycle are still marked valid, so they are never handed out.
   always_comb begin
      logic [DEPTH-1:0] avail;
      logic             found;
      avail        = ~r_valid;
      w_alloc_mask = '0;
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
         w_alloc_en[l]  = disp_ready && disp_valid[l];
         w_alloc_idx[l] = '0;
         found          = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            if (!found && avail[i]) begin
               found          = 1'b1;
               w_alloc_idx[l] = IDXW'(i);
            end
         end
         if (w_alloc_en[l]) begin
            avail[w_alloc_idx[l]]        = 1'b0;
            w_alloc_mask[w_alloc_idx[l]] = 1'b1;
         end
      end
   end

   // Entry i is the oldest candidate when no other candidate is older than it,
   // i.e. every other candidate is covered by row i of the age matrix.
   always_comb begin
      logic [DEPTH-1:0] cand;
      cand = r_valid & r_s1_rdy & r_s2_rdy;
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
         w_sel_v[p]   = 1'b0;
         w_sel_idx[p] = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && ((cand & ~r_age[i] & ~(DEPTH'(1) << i)) == '0)) begin
               w_sel_v[p]   = 1'b1;
               w_sel_idx[p] = IDXW'(i);
            end
         end
         if (w_sel_v[p]) cand[w_sel_idx[p]] = 1'b0;
      end
   end

   always_comb begin
      iss_valid    = '0;
      iss_alu_cmd  = '0;
      iss_src1     = '0;
      iss_src2     = '0;
      iss_rd       = '0;
      iss_rob      = '0;
      w_issue_mask = '0;
      for (int p = 0; p < ISSUE_WIDTH; p++) begin
         if (w_sel_v[p] && !flush) begin
            iss_valid[p]                   = 1'b1;
            iss_alu_cmd[p*CMD_W +: CMD_W]  = r_cmd[w_sel_idx[p]];
            iss_src1[p*XLEN +: XLEN]       = r_s1_val[w_sel_idx[p]];
            iss_src2[p*XLEN +: XLEN]       = r_s2_val[w_sel_idx[p]];
            iss_rd[p*PREG_W +: PREG_W]     = r_rd[w_sel_idx[p]];
            iss_rob[p*ROB_W +: ROB_W]      = r_rob[w_sel_idx[p]];
            if (iss_ready[p]) w_issue_mask[w_sel_idx[p]] = 1'b1;
         end
      end
   end

   // New entries are younger than everything valid before the edge; among
   // same-cycle lanes the lower lane is older.
   always_comb begin
      for (int e = 0; e < DEPTH; e++) w_age_n[e] = r_age[e];
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
         if (w_alloc_en[l]) begin
            w_age_n[w_alloc_idx[l]] = '0;
            for (int e = 0; e < DEPTH; e++) w_age_n[e][w_alloc_idx[l]] = r_valid[e];
         end
      end
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
         for (int m = l + 1; m < DISPATCH_WIDTH; m++) begin
            if (w_alloc_en[l] && w_alloc_en[m]) w_age_n[w_alloc_idx[l]][w_alloc_idx[m]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid <= '0;
         for (int e = 0; e < DEPTH; e++) r_age[e] <= '0;
      end else begin
         r_valid <= (r_valid & ~w_issue_mask) | w_alloc_mask;
         for (int e = 0; e < DEPTH; e++) r_age[e] <= w_age_n[e];
         for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_s1_rdy[i] && w_s1_hit[i]) begin
               r_s1_rdy[i] <= 1'b1;
               r_s1_val[i] <= w_s1_wdat[i];
            end
            if (r_valid[i] && !r_s2_rdy[i] && w_s2_hit[i]) begin
               r_s2_rdy[i] <= 1'b1;
               r_s2_val[i] <= w_s2_wdat[i];
            end
         end
         for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            if (w_alloc_en[l]) begin
               r_cmd[w_alloc_idx[l]]    <= disp_alu_cmd[l*CMD_W +: CMD_W];
               r_rd[w_alloc_idx[l]]     <= disp_rd[l*PREG_W +: PREG_W];
               r_rob[w_alloc_idx[l]]    <= disp_rob[l*ROB_W +: ROB_W];
               r_s1_rdy[w_alloc_idx[l]] <= disp_src1_rdy[l] | w_d1_hit[l];
               r_s2_rdy[w_alloc_idx[l]] <= disp_src2_rdy[l] | w_d2_hit[l];
               r_s1_val[w_alloc_idx[l]] <= (!disp_src1_rdy[l] && w_d1_hit[l]) ?
                                           w_d1_wdat[l] : disp_src1[l*XLEN +: XLEN];
               r_s2_val[w_alloc_idx[l]] <= (!disp_src2_rdy[l] && w_d2_hit[l]) ?
                                           w_d2_wdat[l] : disp_src2[l*XLEN +: XLEN];
            end
         end
      end
   end

endmodule

// File: tb/tb_age_issue_queue.sv
// tb/tb_age_issue_queue.sv - directed self-checking bench for age_issue_queue
module tb_age_issue_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  disp_valid;
   logic        disp_ready;
   logic [9:0]  disp_alu_cmd;
   logic [1:0]  disp_src1_rdy;
   logic [1:0]  disp_src2_rdy;
   logic [63:0] disp_src1;
   logic [63:0] disp_src2;
   logic [11:0] disp_rd;
   logic [7:0]  disp_rob;
   logic [1:0]  wb_valid;
   logic [11:0] wb_preg;
   logic [63:0] wb_data;
   logic [1:0]  iss_valid;
   logic [1:0]  iss_ready;
   logic [9:0]  iss_alu_cmd;
   logic [63:0] iss_src1;
   logic [63:0] iss_src2;
   logic [11:0] iss_rd;
   logic [7:0]  iss_rob;
   logic [3:0]  free_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   age_issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_cmd(disp_alu_cmd),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_rd(disp_rd), .disp_rob(disp_rob),
      .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_alu_cmd(iss_alu_cmd),
      .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_rd(iss_rd), .iss_rob(iss_rob),
      .free_count(free_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      flush = 1'b0; disp_valid = '0; disp_alu_cmd = '0;
      disp_src1_rdy = '0; disp_src2_rdy = '0; disp_src1 = '0; disp_src2 = '0;
      disp_rd = '0; disp_rob = '0; wb_valid = '0; wb_preg = '0; wb_data = '0;
      iss_ready = '0;
   endtask

   task automatic lane(input int l, input logic [4:0] cmd, input logic r1, input logic [31:0] s1,
                       input logic r2, input logic [31:0] s2, input logic [5:0] rd, input logic [3:0] rob);
      disp_valid[l]         = 1'b1;
      disp_alu_cmd[l*5 +: 5] = cmd;
      disp_src1_rdy[l]      = r1;
      disp_src1[l*32 +: 32] = s1;
      disp_src2_rdy[l]      = r2;
      disp_src2[l*32 +: 32] = s2;
      disp_rd[l*6 +: 6]     = rd;
      disp_rob[l*4 +: 4]    = rob;
   endtask

   // Advance one rising edge and land 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_free", free_count, 8);
      chk("rst_iss_valid", iss_valid, 0);
      chk("rst_disp_ready", disp_ready, 1);

      // Two ready lanes dispatched together, lane 0 older.
      lane(0, 5'd3, 1'b1, 32'd5, 1'b1, 32'd7, 6'd10, 4'd1);
      lane(1, 5'd4, 1'b1, 32'd5, 1'b1, 32'd7, 6'd11, 4'd2);
      #1 chk("t1_disp_ready", disp_ready, 1);
      step(); idle(); #1;
      chk("t1_iss_valid", iss_valid, 2'b11);
      chk("t1_iss_rob", iss_rob, 8'h21);
      chk("t1_iss_src1", iss_src1, {32'd5, 32'd5});
      chk("t1_iss_src2", iss_src2, {32'd7, 32'd7});
      chk("t1_iss_cmd", iss_alu_cmd, 10'h083);
      chk("t1_iss_rd", iss_rd, 12'h2CA);
      chk("t1_free", free_count, 6);
      iss_ready = 2'b11;
      step(); idle(); #1;
      chk("t1_free_after", free_count, 8);
      chk("t1_empty", iss_valid, 0);

      // Wakeup of src1 after idle cycles; both wb ports match, port 0 wins.
      lane(0, 5'd1, 1'b0, 32'd9, 1'b1, 32'd2, 6'd12, 4'd3);
      step(); idle(); #1;
      chk("t2_free", free_count, 7);
      step(); step(); step();
      chk("t2_wait", iss_valid, 0);
      wb_valid = 2'b11; wb_preg = {6'd9, 6'd9}; wb_data = {32'hBEEF, 32'hDEAD};
      #1 chk("t2_wb_cycle", iss_valid, 0);
      step(); idle(); #1;
      chk("t2_iss_valid", iss_valid, 2'b01);
      chk("t2_iss_src1", iss_src1, 64'hDEAD);
      chk("t2_iss_src2", iss_src2, 64'h2);
      chk("t2_iss_rob", iss_rob, 8'h03);
      iss_ready = 2'b01;
      step(); idle(); #1;
      chk("t2_free_after", free_count, 8);

      // Build a full queue whose oldest entry X sits at index 7.
      for (int k = 0; k < 3; k++) begin
         lane(0, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'(2*k+1));
         lane(1, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'(2*k+2));
         step(); idle();
      end
      lane(0, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd7);
      lane(1, 5'd0, 1'b0, 32'd30, 1'b1, 32'd1, 6'd1, 4'd15);
      step(); idle(); #1;
      chk("t3_full_ready", disp_ready, 0);
      chk("t3_full_free", free_count, 0);
      for (int k = 0; k < 4; k++) begin
         iss_ready = 2'b11;
         step();
      end
      idle(); #1;
      chk("t3_drain_free", free_count, 7);
      chk("t3_drain_valid", iss_valid, 0);
      lane(0, 5'd0, 1'b0, 32'd40, 1'b1, 32'd1, 6'd1, 4'd8);
      lane(1, 5'd0, 1'b0, 32'd41, 1'b1, 32'd1, 6'd1, 4'd9);
      step(); idle();
      lane(0, 5'd0, 1'b0, 32'd42, 1'b1, 32'd1, 6'd1, 4'd10);
      lane(1, 5'd0, 1'b0, 32'd43, 1'b1, 32'd1, 6'd1, 4'd11);
      step(); idle();
      lane(1, 5'd0, 1'b0, 32'd44, 1'b1, 32'd1, 6'd1, 4'd12);
      step(); idle();
      lane(0, 5'd0, 1'b0, 32'd45, 1'b1, 32'd1, 6'd1, 4'd13);
      lane(1, 5'd0, 1'b0, 32'd46, 1'b1, 32'd1, 6'd1, 4'd14);
      step(); idle(); #1;
      chk("t3_refill_ready", disp_ready, 0);
      chk("t3_refill_free", free_count, 0);
      chk("t3_refill_valid", iss_valid, 0);
      wb_valid = 2'b11; wb_preg = {6'd40, 6'd30}; wb_data = {32'h40, 32'h1234};
      step(); idle(); #1;
      chk("t3_wake_valid", iss_valid, 2'b11);
      chk("t3_wake_rob", iss_rob, 8'h8F);
      chk("t3_wake_src1", iss_src1, {32'h40, 32'h1234});
      flush = 1'b1;
      step(); idle(); #1;
      chk("t3_clear_free", free_count, 8);

      // Stall both ports, then accept only port 1.
      lane(0, 5'd2, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd4);
      lane(1, 5'd2, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd5);
      step(); idle();
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t4_hold_valid", iss_valid, 2'b11);
         chk("t4_hold_rob", iss_rob, 8'h54);
         step();
      end
      chk("t4_hold_free", free_count, 6);
      iss_ready = 2'b10;
      step(); idle(); #1;
      chk("t4_part_valid", iss_valid, 2'b01);
      chk("t4_part_rob", iss_rob, 8'h04);
      chk("t4_part_free", free_count, 7);
      iss_ready = 2'b11;
      step(); idle(); #1;
      chk("t4_free_after", free_count, 8);

      // Dispatch bypass: wakeup on wb port 1 in the dispatch cycle.
      lane(0, 5'd6, 1'b1, 32'd1, 1'b0, 32'd12, 6'd3, 4'd6);
      wb_valid = 2'b11; wb_preg = {6'd12, 6'd13}; wb_data = {32'h55, 32'h66};
      step(); idle(); #1;
      chk("t5_valid", iss_valid, 2'b01);
      chk("t5_src2", iss_src2, 64'h55);
      chk("t5_rob", iss_rob, 8'h06);
      iss_ready = 2'b01;
      step(); idle();

      // Flush with 5 valid entries and a simultaneous dispatch.
      lane(0, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd1);
      lane(1, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd2);
      step(); idle();
      lane(0, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd3);
      lane(1, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd4);
      step(); idle();
      lane(0, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd5);
      step(); idle(); #1;
      chk("t6_pre_free", free_count, 3);
      flush = 1'b1; iss_ready = 2'b11;
      lane(0, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd6);
      lane(1, 5'd0, 1'b1, 32'd1, 1'b1, 32'd1, 6'd1, 4'd7);
      #1;
      chk("t6_flush_iss", iss_valid, 0);
      chk("t6_flush_ready", disp_ready, 0);
      step(); idle(); #1;
      chk("t6_post_free", free_count, 8);
      chk("t6_post_iss", iss_valid, 0);
      chk("t6_post_ready", disp_ready, 1);
      step(); #1;
      chk("t6_late_iss", iss_valid, 0);
      chk("t6_late_free", free_count, 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
